rx_fir_post: RTL and testbench

Post-filter stage sitting directly downstream of `rx_fir`. It consumes the filter's `rdy`/`dout`/`chan_out` stream, rounds and saturates each 18-bit result to 16 bits, and decimates each of the two interleaved channels independently. Surviving samples are buffered in a small FIFO and presented to the consumer on a valid/ready handshake, with overflow and drop indications for headroom monitoring.

---
 rtl/rx_fir_pkg.sv | 38 +++
 rtl/rx_post_fifo.sv | 52 +++++
 rtl/rx_fir_post.sv | 114 +++++++++++
 tb/tb_rx_fir_post.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_fir_pkg.sv
// Shared constants and round/saturate arithmetic for rx_fir post-processing stages.
package rx_fir_pkg;

  localparam logic CHAN_A = 1'b1;
  localparam logic CHAN_B = 1'b0;

  localparam int RX_DIN_W  = 18;
  localparam int RX_DOUT_W = 16;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } rnd_sat_t;

  // Round half up by dropping 'shift' LSBs, then clamp to signed 'dout_w' bits.
  function automatic rnd_sat_t round_sat(input logic signed [31:0] x, input int shift,
                                         input int dout_w);
    logic signed [32:0] r;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    rnd_sat_t           res;
    if (shift > 0) r = (33'(x) + (33'sd1 <<< (shift - 1))) >>> shift;
    else           r = 33'(x);
    max_v   = (33'sd1 <<< (dout_w - 1)) - 33'sd1;
    min_v   = -(33'sd1 <<< (dout_w - 1));
    res.ovf = 1'b0;
    res.val = r[31:0];
    if (r > max_v) begin
      res.ovf = 1'b1;
      res.val = max_v[31:0];
    end else if (r < min_v) begin
      res.ovf = 1'b1;
      res.val = min_v[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rx_post_fifo.sv
// First-word-fall-through FIFO; accepts a push while full when a pop happens in the same cycle.
module rx_post_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the outputs are clean straight out of reset.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_fir_post.sv
// rx_fir post stage: round/saturate, per-channel decimation, FIFO to a valid/ready consumer.
// Optional saturation counter output ovf_cnt when RX_POST_OVF_CNT_EN is defined.
module rx_fir_post
  import rx_fir_pkg::*;
#(
  parameter int DIN_W      = RX_DIN_W,
  parameter int DOUT_W     = RX_DOUT_W,
  parameter int SHIFT      = 1,
  parameter int DEC        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [DIN_W-1:0]  din,
  input  logic              chan_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DOUT_W-1:0] m_data,
  output logic              m_chan,
  output logic              ovf,
  output logic              drop
`ifdef RX_POST_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  logic              p1_v;
  logic              p1_chan;
  logic [DIN_W-1:0]  p1_dat;
  logic              p2_v;
  logic              p2_chan;
  logic [DOUT_W-1:0] p2_dat;
  rnd_sat_t          rs;
  logic [4:0]        dcnt_a;
  logic [4:0]        dcnt_b;
  logic              keep;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic [DOUT_W:0]   head;

  assign rs = round_sat(32'($signed(p1_dat)), SHIFT, DOUT_W);
  wire unused_rs = ^rs.val[31:DOUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_v    <= 1'b0;
      p1_chan <= 1'b0;
      p1_dat  <= '0;
      p2_v    <= 1'b0;
      p2_chan <= 1'b0;
      p2_dat  <= '0;
      ovf     <= 1'b0;
    end else begin
      p1_v <= rdy;
      if (rdy) begin
        p1_chan <= chan_in;
        p1_dat  <= din;
      end
      p2_v <= p1_v;
      if (p1_v) begin
        p2_chan <= p1_chan;
        p2_dat  <= rs.val[DOUT_W-1:0];
      end
      ovf <= p1_v && rs.ovf;
    end
  end

  // A sample survives when its channel counter is at zero before advancing.
  assign keep = p2_v && ((p2_chan == CHAN_A) ? (dcnt_a == '0) : (dcnt_b == '0));
  assign pop  = m_valid && m_ready;
  assign push = keep && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_a <= '0;
      dcnt_b <= '0;
      drop   <= 1'b0;
    end else begin
      if (p2_v && p2_chan == CHAN_A) dcnt_a <= (dcnt_a == 5'(DEC - 1)) ? '0 : dcnt_a + 5'd1;
      if (p2_v && p2_chan != CHAN_A) dcnt_b <= (dcnt_b == 5'(DEC - 1)) ? '0 : dcnt_b + 5'd1;
      drop <= keep && full && !pop;
    end
  end

  rx_post_fifo #(
    .W     (DOUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({p2_chan, p2_dat}),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  assign m_valid = !empty;
  assign m_chan  = head[DOUT_W];
  assign m_data  = head[DOUT_W-1:0];

`ifdef RX_POST_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt <= '0;
    else if (ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rx_fir_post.sv
// Bench for rx_fir_post: DEC=1 and DEC=4 instances share stimulus, checked against a queue model.
module tb_rx_fir_post;

  localparam int SHIFT = 1;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [17:0] din;
  logic        chan_in;
  logic        m_ready;
  logic        m_valid1, m_chan1, ovf1, drop1;
  logic        m_valid4, m_chan4, ovf4, drop4;
  logic [15:0] m_data1, m_data4;
`ifdef RX_POST_OVF_CNT_EN
  logic [15:0] ovf_cnt1, ovf_cnt4;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [16:0] exp1[$], exp4[$], got1[$], got4[$];
  int exp_ovf, exp_drop1, exp_drop4;
  int ovf_seen1, ovf_seen4, drop_seen1, drop_seen4;
  int cnt_a, cnt_b;
  bit stalled;

  rx_fir_post #(.DEC(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .din(din), .chan_in(chan_in),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_chan(m_chan1),
    .ovf(ovf1), .drop(drop1)
`ifdef RX_POST_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt1)
`endif
  );

  rx_fir_post #(.DEC(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .rdy(rdy), .din(din), .chan_in(chan_in),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_chan(m_chan4),
    .ovf(ovf4), .drop(drop4)
`ifdef RX_POST_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt4)
`endif
  );

  always #5 clk = ~clk;

  // Observe between edges: handshakes, overflow and drop pulses.
  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      if (m_valid1 && m_ready) got1.push_back({m_chan1, m_data1});
      if (m_valid4 && m_ready) got4.push_back({m_chan4, m_data4});
      if (ovf1)  ovf_seen1++;
      if (ovf4)  ovf_seen4++;
      if (drop1) drop_seen1++;
      if (drop4) drop_seen4++;
    end
  end

  task automatic clear_q();
    exp1.delete(); exp4.delete(); got1.delete(); got4.delete();
    exp_ovf = 0; exp_drop1 = 0; exp_drop4 = 0;
    ovf_seen1 = 0; ovf_seen4 = 0; drop_seen1 = 0; drop_seen4 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b0; din = '0; chan_in = 1'b0; m_ready = 1'b1; stalled = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
    cnt_a = 0; cnt_b = 0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rdy = 1'b0;
      if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Drive one sample (rdy left high) and predict its fate in both instances.
  task automatic send(input logic [17:0] x, input logic c);
    int v, r, n;
    logic [16:0] e;
    @(negedge clk);
    rdy = 1'b1; din = x; chan_in = c;
    v = $signed(x);
    r = int'($floor(real'(v) / (2.0 ** SHIFT) + 0.5));
    if (r > 32767)  begin r = 32767;  exp_ovf++; end
    if (r < -32768) begin r = -32768; exp_ovf++; end
    e = {c, 16'(r)};
    if (stalled && exp1.size() >= DEPTH) exp_drop1++;
    else exp1.push_back(e);
    n = c ? cnt_a : cnt_b;
    if (c) cnt_a++; else cnt_b++;
    if (n % 4 == 0) begin
      if (stalled && exp4.size() >= DEPTH) exp_drop4++;
      else exp4.push_back(e);
    end
  endtask

  task automatic check_stream(input string name);
    idle(24, 1'b0);
    nvec++;
    if (got1.size() != exp1.size()) begin
      nerr++; $display("FAIL %s dec1 count: got %0d want %0d", name, got1.size(), exp1.size());
    end
    for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
      nvec++;
      if (got1[i] !== exp1[i]) begin
        nerr++; $display("FAIL %s dec1 item %0d: got %h want %h", name, i, got1[i], exp1[i]);
      end
    end
    nvec++;
    if (got4.size() != exp4.size()) begin
      nerr++; $display("FAIL %s dec4 count: got %0d want %0d", name, got4.size(), exp4.size());
    end
    for (int i = 0; i < got4.size() && i < exp4.size(); i++) begin
      nvec++;
      if (got4[i] !== exp4[i]) begin
        nerr++; $display("FAIL %s dec4 item %0d: got %h want %h", name, i, got4[i], exp4[i]);
      end
    end
    nvec++;
    if (ovf_seen1 != exp_ovf || ovf_seen4 != exp_ovf) begin
      nerr++; $display("FAIL %s ovf pulses: got %0d/%0d want %0d", name, ovf_seen1, ovf_seen4, exp_ovf);
    end
    nvec++;
    if (drop_seen1 != exp_drop1 || drop_seen4 != exp_drop4) begin
      nerr++; $display("FAIL %s drop pulses: got %0d/%0d want %0d/%0d", name,
                       drop_seen1, drop_seen4, exp_drop1, exp_drop4);
    end
    nvec++;
    if (m_valid1 !== 1'b0 || m_valid4 !== 1'b0) begin
      nerr++; $display("FAIL %s m_valid after drain: got %b/%b want 0/0", name, m_valid1, m_valid4);
    end
    clear_q();
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; din = '0; chan_in = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    nvec++;
    if ({m_valid1, m_data1, m_chan1, ovf1, drop1, m_valid4, m_data4, m_chan4, ovf4, drop4} !== '0) begin
      nerr++; $display("FAIL reset_state: got %b%h%b%b%b want all zero", m_valid1, m_data1, m_chan1, ovf1, drop1);
    end
    do_reset();
    m_ready = 1'b0; stalled = 1'b1;
    for (int i = 0; i < 3; i++) send(18'(20 + i), 1'b1);
    idle(5, 1'b0);
    #3;
    nvec++;
    if (m_valid1 !== 1'b1) begin
      nerr++; $display("FAIL reset_pre_traffic m_valid: got %b want 1", m_valid1);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    nvec++;
    if ({m_valid1, m_data1, m_chan1, m_valid4, m_data4, m_chan4} !== '0) begin
      nerr++; $display("FAIL reset_async: got v=%b d=%h c=%b want 0", m_valid1, m_data1, m_chan1);
    end
    @(negedge clk);
    clear_q();
    cnt_a = 0; cnt_b = 0;
    rst = 1'b0; m_ready = 1'b1; stalled = 1'b0;
    send(18'd7, 1'b1); idle(2, 1'b0);
    send(18'd9, 1'b0); idle(2, 1'b0);
    check_stream("reset_rekeep");
  endtask

  task automatic test_rounding();
    do_reset();
    send(18'd5, 1'b0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      rdy = 1'b0;
      #3;
      nvec++;
      if (cyc == 3) begin
        if (m_valid1 !== 1'b1 || m_data1 !== 16'd3 || m_chan1 !== 1'b0) begin
          nerr++; $display("FAIL round_latency c3: got v=%b d=%h c=%b want 1/0003/0", m_valid1, m_data1, m_chan1);
        end
      end else if (m_valid1 !== 1'b0) begin
        nerr++; $display("FAIL round_latency c%0d: got v=%b want 0", cyc, m_valid1);
      end
    end
    send(18'h3FFFD, 1'b0); idle(3, 1'b0);
    check_stream("round");
  endtask

  task automatic test_saturation();
    do_reset();
    send(18'h1FFFF, 1'b1);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      rdy = 1'b0;
      #3;
      nvec++;
      if (ovf1 !== (cyc == 2)) begin
        nerr++; $display("FAIL sat_ovf_align c%0d: got %b want %b", cyc, ovf1, cyc == 2);
      end
    end
    send(18'h20000, 1'b1); idle(4, 1'b0);
    send(18'h0FFFE, 1'b1); idle(4, 1'b0);
    check_stream("sat");
  endtask

  task automatic test_decimation();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(18'(i), 1'b1);       idle(2, 1'b0);
      send(18'(100 + i), 1'b0); idle(2, 1'b0);
    end
    check_stream("decim");
  endtask

  task automatic test_backpressure();
    logic [16:0] head0;
    do_reset();
    m_ready = 1'b0; stalled = 1'b1;
    for (int i = 0; i < 9; i++) send(18'(i * 10 + 1), 1'b0);
    idle(6, 1'b0);
    head0 = exp1[0];
    for (int k = 0; k < 2; k++) begin
      #3;
      nvec++;
      if (m_valid1 !== 1'b1 || {m_chan1, m_data1} !== head0) begin
        nerr++; $display("FAIL bp_hold %0d: got v=%b %h want 1 %h", k, m_valid1, {m_chan1, m_data1}, head0);
      end
      idle(3, 1'b0);
    end
    stalled = 1'b0; m_ready = 1'b1;
    check_stream("backpressure");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 12; i++) send(18'($urandom), 1'($urandom));
    check_stream("back_to_back");
  endtask

  task automatic test_random();
    logic [17:0] x;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      x = 18'($urandom);
      if ($urandom_range(0, 7) == 0) x = {x[17], {17{~x[17]}}};
      send(x, 1'($urandom));
      idle($urandom_range(2, 4), 1'b1);
    end
    m_ready = 1'b1;
    check_stream("random");
  endtask

`ifdef RX_POST_OVF_CNT_EN
  task automatic test_ovf_cnt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(18'h1FFFF, 1'($urandom)); idle(3, 1'b0);
    end
    idle(4, 1'b0);
    #3;
    nvec++;
    if (ovf_cnt1 !== 16'd3 || ovf_cnt4 !== 16'd3) begin
      nerr++; $display("FAIL ovf_cnt: got %0d/%0d want 3", ovf_cnt1, ovf_cnt4);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (ovf_cnt1 !== 16'd0) begin
      nerr++; $display("FAIL ovf_cnt_reset: got %0d want 0", ovf_cnt1);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef RX_POST_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
